// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record kinds, capture states, record layout.
// Record width grows by TS_W when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  localparam int TS_W       = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    MARKER = 2'b00,
    REG    = 2'b01,
    MEM_WR = 2'b10,
    MEM_RD = 2'b11
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e             kind;
    logic [DEF_ADDR_W-1:0]   idx;
    logic [DEF_DATA_W-1:0]   data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } trace_state_e;

  function automatic int rec_w(int data_w, int addr_w);
`ifdef TRACE_TIMESTAMP_EN
    return 2 + addr_w + data_w + TS_W;
`else
    return 2 + addr_w + data_w;
`endif
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Valid/ready record stream leaving the trace buffer.
interface commit_trace_buffer_if #(
  parameter int REC_W = 43
) ();
  logic             t_valid;
  logic             t_ready;
  logic [REC_W-1:0] t_data;

  modport master (output t_valid, output t_data, input t_ready);
  modport slave  (input t_valid, input t_data, output t_ready);
endinterface

// File: rtl/trace_fifo_2w.sv
// Dual-push, single-pop first-word-fall-through FIFO; push1 lands behind push0.
// The writer never pushes more than the free space, so there is no full guard.
module trace_fifo_2w #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push0,
  input  logic                       push1,
  input  logic [WIDTH-1:0]           din0,
  input  logic [WIDTH-1:0]           din1,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (level != '0);

  // NOTE: storage has no reset; level gates the output so stale entries never show.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= din0;
    if (push1) mem[wr_ptr + PTR_W'(push0)] <= din1;
  end

  // NOTE: clocked state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(pop_ok);
      level  <= level + LVL_W'(push0) + LVL_W'(push1) - LVL_W'(pop_ok);
    end
  end

  assign dout = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/commit_trace_buffer.sv
// Packs core write-back and data-memory events into trace records, queues them, and
// reports overflow in-band with MARKER records. Optional macro: TRACE_TIMESTAMP_EN.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trace_en,
  input  logic                      reg_write_sig,
  input  logic [4:0]                reg_num,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W-1:0]         rd_data,
  commit_trace_buffer_if.master     tr,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               overflow_cnt
);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int BASE_W = 2 + ADDR_W + DATA_W;
  localparam int REC_W  = rec_w(DATA_W, ADDR_W);

  trace_state_e      state;
  logic [DATA_W-1:0] lost_cnt;

  logic              reg_ev, mem_ev, fits, run_now, lost_now, marker_now, drop_now;
  logic [1:0]        n;
  logic [LVL_W-1:0]  free;
  logic [DATA_W:0]   lost_ext;
  logic [DATA_W-1:0] lost_sum;
  logic [16:0]       ovf_ext;
  logic [15:0]       ovf_sum;
  logic [BASE_W-1:0] reg_rec, mem_rec, marker_rec, base0, base1;
  logic [REC_W-1:0]  din0, din1;
  logic              push0, push1;

  assign reg_ev = reg_write_sig && (reg_num != 5'd0);
  assign mem_ev = wr || rd;
  assign n      = 2'(reg_ev) + 2'(mem_ev);

  assign reg_rec    = {REG, ADDR_W'(reg_num), reg_data};
  assign mem_rec    = wr ? {MEM_WR, addr, wr_data} : {MEM_RD, addr, rd_data};
  assign marker_rec = {MARKER, {ADDR_W{1'b0}}, lost_sum};

  // Credit comes only from the registered level; a same-cycle pop does not help.
  assign free       = LVL_W'(DEPTH) - level;
  assign fits       = free >= LVL_W'(n);
  assign run_now    = trace_en && (state != LOST);
  assign lost_now   = trace_en && (state == LOST);
  assign marker_now = lost_now && (level <= LVL_W'(DEPTH / 2));
  assign drop_now   = (run_now && !fits) || lost_now;

  assign lost_ext = {1'b0, lost_cnt} + (DATA_W + 1)'(n);
  assign lost_sum = lost_ext[DATA_W] ? '1 : lost_ext[DATA_W-1:0];
  assign ovf_ext  = {1'b0, overflow_cnt} + 17'(n);
  assign ovf_sum  = ovf_ext[16] ? '1 : ovf_ext[15:0];

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    push0 = 1'b0;
    push1 = 1'b0;
    base0 = reg_rec;
    base1 = mem_rec;
    if (marker_now) begin
      push0 = 1'b1;
      base0 = marker_rec;
    end else if (run_now && fits) begin
      push0 = (n != 2'd0);
      push1 = (n == 2'd2);
      if (!reg_ev) base0 = mem_rec;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  assign din0 = {base0, ts};
  assign din1 = {base1, ts};
`else
  assign din0 = base0;
  assign din1 = base1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= OFF;
      lost_cnt     <= '0;
      overflow_cnt <= '0;
    end else begin
      if (drop_now) overflow_cnt <= ovf_sum;
      if (!trace_en) begin
        state    <= OFF;
        lost_cnt <= '0;
      end else begin
        case (state)
          OFF, RUN: begin
            if (!fits) begin
              state    <= LOST;
              lost_cnt <= DATA_W'(n);
            end else begin
              state <= RUN;
            end
          end
          LOST: begin
            if (marker_now) begin
              state    <= RUN;
              lost_cnt <= '0;
            end else begin
              lost_cnt <= lost_sum;
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

  trace_fifo_2w #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push0 (push0),
    .push1 (push1),
    .din0  (din0),
    .din1  (din1),
    .pop   (tr.t_valid && tr.t_ready),
    .dout  (tr.t_data),
    .level (level)
  );

  assign tr.t_valid = (level != '0);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: vector table plus overflow/marker/reset sequences,
// with a scoreboard queue compared against every popped record.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int BASE_W = 2 + ADDR_W + DATA_W;
  localparam int REC_W  = rec_w(DATA_W, ADDR_W);

  logic              clk;
  logic              reset;
  logic              trace_en;
  logic              reg_write_sig;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]  level;
  logic [15:0]       overflow_cnt;

  commit_trace_buffer_if #(.REC_W(REC_W)) tr_if ();

  commit_trace_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trace_en      (trace_en),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .tr            (tr_if),
    .level         (level),
    .overflow_cnt  (overflow_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [BASE_W-1:0] sb [$];
  logic [BASE_W-1:0] exp_rec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pop side: a record is consumed at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (reset === 1'b1 && tr_if.t_valid === 1'b1 && tr_if.t_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_record: got %0h, expected none", tr_if.t_data);
      end else begin
        exp_rec = sb.pop_front();
        check("record", 64'(tr_if.t_data[REC_W-1 -: BASE_W]), 64'(exp_rec));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_sig = 1'b0;
    wr            = 1'b0;
    rd            = 1'b0;
  endtask

  task automatic reg_event(input logic [4:0] num, input logic [31:0] data);
    reg_write_sig = 1'b1;
    reg_num       = num;
    reg_data      = data;
    wr            = 1'b0;
    rd            = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && level != '0; i++) tick();
    check("drain_level", 64'(level), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic        rws;
    logic [4:0]  rn;
    logic [31:0] rdat;
    logic        w;
    logic        r;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rdd;
    int          n;
    logic [42:0] e0;
    logic [42:0] e1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 9'h010, 32'h12,       32'h0,        2,
                {2'b01, 9'h005, 32'hDEADBEEF}, {2'b10, 9'h010, 32'h00000012}};
    vecs[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 1'b0, 9'h000, 32'h0,        32'h0,        0,
                43'h0, 43'h0};
    vecs[2] = '{1'b0, 5'd9,  32'h0,        1'b0, 1'b1, 9'h1FF, 32'h0,        32'hCAFEF00D, 1,
                {2'b11, 9'h1FF, 32'hCAFEF00D}, 43'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 9'h0AA, 32'h55,       32'h77,       1,
                {2'b10, 9'h0AA, 32'h00000055}, 43'h0};
    vecs[4] = '{1'b1, 5'd31, 32'h1,        1'b0, 1'b1, 9'h003, 32'h0,        32'hABCD,     2,
                {2'b01, 9'h01F, 32'h00000001}, {2'b11, 9'h003, 32'h0000ABCD}};
    vecs[5] = '{1'b1, 5'd0,  32'h9,        1'b1, 1'b0, 9'h000, 32'hFFFFFFFF, 32'h0,        1,
                {2'b10, 9'h000, 32'hFFFFFFFF}, 43'h0};
    vecs[6] = '{1'b0, 5'd3,  32'h5,        1'b0, 1'b0, 9'h100, 32'h1,        32'h2,        0,
                43'h0, 43'h0};
    vecs[7] = '{1'b1, 5'd1,  32'h0,        1'b0, 1'b0, 9'h044, 32'h3,        32'h4,        1,
                {2'b01, 9'h001, 32'h00000000}, 43'h0};

    reset = 1'b0;
    trace_en = 1'b0;
    tr_if.t_ready = 1'b0;
    reg_num = '0; reg_data = '0; addr = '0; wr_data = '0; rd_data = '0;
    idle();
    #12;
    check("rst_valid", 64'(tr_if.t_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow_cnt), 64'd0);
    check("rst_data", 64'(tr_if.t_data[REC_W-1 -: BASE_W]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table: first vector also raises trace_en, so OFF must capture that same cycle.
    tr_if.t_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      trace_en      = 1'b1;
      reg_write_sig = vecs[i].rws;
      reg_num       = vecs[i].rn;
      reg_data      = vecs[i].rdat;
      wr            = vecs[i].w;
      rd            = vecs[i].r;
      addr          = vecs[i].a;
      wr_data       = vecs[i].wd;
      rd_data       = vecs[i].rdd;
      if (vecs[i].n >= 1) sb.push_back(vecs[i].e0);
      if (vecs[i].n == 2) sb.push_back(vecs[i].e1);
      tick();
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].n));
      idle();
      repeat (3) tick();
      check($sformatf("vec%0d_drained", i), 64'(level), 64'd0);
    end
    check("table_sb_empty", 64'(sb.size()), 64'd0);

    // Fill to DEPTH with the consumer stalled, then overflow by three.
    tr_if.t_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      reg_event(5'(i + 1), 32'hA0000000 + 32'(i));
      sb.push_back({2'b01, 9'(i + 1), 32'hA0000000 + 32'(i)});
      tick();
    end
    check("full_level", 64'(level), 64'd16);
    for (int k = 0; k < 3; k++) begin
      reg_event(5'd7, 32'h0000BAD0 + 32'(k));
      tick();
    end
    idle();
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_cnt3", 64'(overflow_cnt), 64'd3);
    tick();
    check("lost_no_marker_yet", 64'(level), 64'd16);

    // Drain: marker lands when registered level is DEPTH/2, alongside a pop.
    sb.push_back({2'b00, 9'h000, 32'd3});
    tr_if.t_ready = 1'b1;
    repeat (9) tick();
    check("marker_level_a", 64'(level), 64'd8);
    tick();
    check("marker_level_b", 64'(level), 64'd7);
    drain();
    reg_event(5'd2, 32'h0000600D);
    sb.push_back({2'b01, 9'h002, 32'h0000600D});
    tick();
    idle();
    drain();

    // Level 15 with two events: all-or-nothing drop.
    tr_if.t_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      reg_event(5'(i + 1), 32'hB0000000 + 32'(i));
      sb.push_back({2'b01, 9'(i + 1), 32'hB0000000 + 32'(i)});
      tick();
    end
    check("lvl15", 64'(level), 64'd15);
    reg_event(5'd4, 32'h1);
    wr = 1'b1; addr = 9'h005; wr_data = 32'h2;
    tick();
    idle();
    check("dual_drop_level", 64'(level), 64'd15);
    check("dual_drop_ovf", 64'(overflow_cnt), 64'd5);

    // Disable capture, pop five, then reset asynchronously mid-cycle.
    trace_en = 1'b0;
    tr_if.t_ready = 1'b1;
    repeat (5) tick();
    tr_if.t_ready = 1'b0;
    check("lvl10", 64'(level), 64'd10);
    check("ovf_retained", 64'(overflow_cnt), 64'd5);
    #3;
    reset = 1'b0;
    #1;
    check("async_valid", 64'(tr_if.t_valid), 64'd0);
    check("async_level", 64'(level), 64'd0);
    check("async_ovf", 64'(overflow_cnt), 64'd0);
    check("async_data", 64'(tr_if.t_data[REC_W-1 -: BASE_W]), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    trace_en = 1'b1;
    tr_if.t_ready = 1'b1;
    reg_event(5'd3, 32'h00000007);
    sb.push_back({2'b01, 9'h003, 32'h00000007});
    tick();
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
